// File: rtl/patch_stream_gen.sv
// patch_stream_gen
//   Fetches a KxK window (all C channels) from a single-port image memory
//   with 1-cycle read latency and presents it as one wide patch word.
//   Window reuse:
//     HIT   - same coordinate as the held window: no reads at all.
//     SHIFT - same row, column advanced by STRIDE: only the STRIDE new
//             columns are read, and the held window slides left.
//     FULL  - anything else: all K*K taps are read.
//
// Optional feature macro: PATCH_PAD_EN
//   Defined  : req_i/req_j give the window centre, with K/2 zero padding on
//              every side. Taps outside the image keep their slot cycle
//              with mem_rd_en=0 and load zero.
//   Undefined: req_i/req_j give the top-left corner, and windows that do not
//              fit inside the image are rejected.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_ready, req_i, req_j    window request
//   mem_rd_en, mem_addr, mem_rd_data     image memory (data valid the cycle
//                                        after mem_rd_en)
//   patch_valid/patch_ready, patch_data  patch output; element (r,c,ch) at
//                                        bit ((r*K+c)*C+ch)*DW
//   full_load     patch came from a full KxK fetch
//   req_err       one-cycle pulse when a request is rejected
//   dbg_state     current FSM state (0 IDLE, 1 FETCH, 2 OUT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is 1 only in IDLE. patch_valid stays high with
// patch_data stable until patch_ready is sampled high. There is no request
// queueing: a request that coincides with the patch handshake is taken one
// cycle later, from IDLE.
module patch_stream_gen #(
  parameter int H      = 28,
  parameter int W      = 28,
  parameter int K      = 3,
  parameter int C      = 1,
  parameter int DW     = 8,
  parameter int STRIDE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(H)-1:0]     req_i,
  input  logic [$clog2(W)-1:0]     req_j,
  output logic                     mem_rd_en,
  output logic [$clog2(H*W)-1:0]   mem_addr,
  input  logic [C*DW-1:0]          mem_rd_data,
  output logic                     patch_valid,
  input  logic                     patch_ready,
  output logic [K*K*C*DW-1:0]      patch_data,
  output logic                     full_load,
  output logic                     req_err,
  output logic [1:0]               dbg_state
);

  localparam int IW = $clog2(H);
  localparam int JW = $clog2(W);
  localparam int AW = $clog2(H*W);
  localparam int PW = C*DW;
  localparam int NB = K*K*PW;
  localparam int CW = ((IW > JW) ? IW : JW) + 2;
  localparam int NW = $clog2(K) + 1;
`ifdef PATCH_PAD_EN
  localparam int P = K/2;
`else
  localparam int P = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NB-1:0]        win_q, win_d;
  logic                 win_valid_q, win_valid_d;
  logic [IW-1:0]        last_i_q, last_i_d;
  logic [JW-1:0]        last_j_q, last_j_d;
  // Top-left image coordinate of the window; negative when padding applies.
  logic signed [CW-1:0] top_i_q, top_i_d;
  logic signed [CW-1:0] top_j_q, top_j_d;
  // Slot currently on the memory strobe (window row/column).
  logic                 iss_act_q, iss_act_d;
  logic [NW-1:0]        iss_row_q, iss_row_d;
  logic [NW-1:0]        iss_col_q, iss_col_d;
  // Slot whose data is on mem_rd_data this cycle.
  logic                 rsp_q, rsp_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic [NW-1:0]        rsp_row_q, rsp_row_d;
  logic [NW-1:0]        rsp_col_q, rsp_col_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 patch_valid_q, patch_valid_d;
  logic                 full_load_q, full_load_d;
  logic                 req_err_q, req_err_d;
  logic                 req_ready_q, req_ready_d;

  logic                 accept, is_err, is_hit, is_shift, iss_go, inb;
  logic signed [CW-1:0] s_top_i, s_top_j;
  logic [NW-1:0]        s_row, s_col;
  int                   ri, rj, ir, jc;

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    win_valid_d   = win_valid_q;
    last_i_d      = last_i_q;
    last_j_d      = last_j_q;
    top_i_d       = top_i_q;
    top_j_d       = top_j_q;
    rsp_d         = 1'b0;
    rsp_last_d    = 1'b0;
    rsp_zero_d    = 1'b0;
    rsp_row_d     = rsp_row_q;
    rsp_col_d     = rsp_col_q;
    iss_act_d     = 1'b0;
    iss_row_d     = iss_row_q;
    iss_col_d     = iss_col_q;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    patch_valid_d = patch_valid_q;
    full_load_d   = full_load_q;
    req_err_d     = 1'b0;
    iss_go        = 1'b0;
    s_top_i       = top_i_q;
    s_top_j       = top_j_q;
    s_row         = '0;
    s_col         = '0;

    ri = int'(req_i);
    rj = int'(req_j);
`ifdef PATCH_PAD_EN
    is_err = (ri > H-1) || (rj > W-1);
`else
    is_err = (ri > H-K) || (rj > W-K);
`endif
    is_hit   = win_valid_q && (ri == int'(last_i_q)) && (rj == int'(last_j_q));
    is_shift = win_valid_q && (ri == int'(last_i_q)) &&
               (rj == int'(last_j_q) + STRIDE);
    accept   = (state_q == S_IDLE) && req_valid && req_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_err) begin
            req_err_d   = 1'b1;
            win_valid_d = 1'b0;
          end else begin
            last_i_d = req_i;
            last_j_d = req_j;
            if (is_hit) begin
              state_d       = S_OUT;
              patch_valid_d = 1'b1;
            end else begin
              state_d = S_FETCH;
              iss_go  = 1'b1;
              s_top_i = CW'(ri - P);
              s_top_j = CW'(rj - P);
              top_i_d = s_top_i;
              top_j_d = s_top_j;
              if (is_shift) begin
                full_load_d = 1'b0;
                s_col       = NW'(K - STRIDE);
                // Slide the held window left now; the vacated right-hand
                // columns are refilled by the reads that follow.
                for (int r = 0; r < K; r++) begin
                  for (int c = 0; c < K - STRIDE; c++) begin
                    win_d[(r*K+c)*PW +: PW] = win_q[(r*K+c+STRIDE)*PW +: PW];
                  end
                end
              end else begin
                full_load_d = 1'b1;
                s_col       = '0;
              end
            end
          end
        end
      end

      S_FETCH: begin
        if (rsp_q) begin
          win_d[(int'(rsp_row_q)*K + int'(rsp_col_q))*PW +: PW] =
            rsp_zero_q ? '0 : mem_rd_data;
        end
        if (rsp_q && rsp_last_q) begin
          state_d       = S_OUT;
          patch_valid_d = 1'b1;
          win_valid_d   = 1'b1;
        end
        // Column-major slot walk: rows 0..K-1 within each column.
        if (iss_act_q && !((iss_row_q == NW'(K-1)) && (iss_col_q == NW'(K-1)))) begin
          iss_go = 1'b1;
          if (iss_row_q == NW'(K-1)) begin
            s_row = '0;
            s_col = iss_col_q + NW'(1);
          end else begin
            s_row = iss_row_q + NW'(1);
            s_col = iss_col_q;
          end
        end
        rsp_d      = iss_act_q;
        rsp_row_d  = iss_row_q;
        rsp_col_d  = iss_col_q;
        rsp_last_d = iss_act_q && (iss_row_q == NW'(K-1)) && (iss_col_q == NW'(K-1));
        // A slot with no strobe is a padding tap and loads zero.
        rsp_zero_d = !mem_rd_en_q;
      end

      S_OUT: begin
        if (patch_ready) begin
          state_d       = S_IDLE;
          patch_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Image coordinate and address of the slot issued next cycle.
    ir  = int'(s_top_i) + int'(s_row);
    jc  = int'(s_top_j) + int'(s_col);
    inb = (ir >= 0) && (ir < H) && (jc >= 0) && (jc < W);
    if (iss_go) begin
      iss_act_d = 1'b1;
      iss_row_d = s_row;
      iss_col_d = s_col;
      if (inb) begin
        mem_rd_en_d = 1'b1;
        mem_addr_d  = AW'(ir * W + jc);
      end
    end

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      win_q         <= '0;
      win_valid_q   <= 1'b0;
      last_i_q      <= '0;
      last_j_q      <= '0;
      top_i_q       <= '0;
      top_j_q       <= '0;
      iss_act_q     <= 1'b0;
      iss_row_q     <= '0;
      iss_col_q     <= '0;
      rsp_q         <= 1'b0;
      rsp_last_q    <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_row_q     <= '0;
      rsp_col_q     <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      patch_valid_q <= 1'b0;
      full_load_q   <= 1'b0;
      req_err_q     <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      win_valid_q   <= win_valid_d;
      last_i_q      <= last_i_d;
      last_j_q      <= last_j_d;
      top_i_q       <= top_i_d;
      top_j_q       <= top_j_d;
      iss_act_q     <= iss_act_d;
      iss_row_q     <= iss_row_d;
      iss_col_q     <= iss_col_d;
      rsp_q         <= rsp_d;
      rsp_last_q    <= rsp_last_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_row_q     <= rsp_row_d;
      rsp_col_q     <= rsp_col_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      patch_valid_q <= patch_valid_d;
      full_load_q   <= full_load_d;
      req_err_q     <= req_err_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign patch_valid = patch_valid_q;
  assign patch_data  = win_q;
  assign full_load   = full_load_q;
  assign req_err     = req_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_patch_stream_gen.sv
// Bench for patch_stream_gen with H=W=8, K=3, C=1, DW=8, STRIDE=1.
// Image word at (row,col) is row*8+col, which equals the memory address.
module tb_patch_stream_gen;

`ifdef PATCH_PAD_EN
  localparam int P_TB = 1;
`else
  localparam int P_TB = 0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_i;
  logic [2:0]  req_j;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_rd_data;
  logic        patch_valid;
  logic        patch_ready;
  logic [71:0] patch_data;
  logic        full_load;
  logic        req_err;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;

  // {full_load, patch_data} expected per presented patch
  logic [72:0] exp_q[$];
  logic [5:0]  exp_addr_q[$];

  patch_stream_gen #(
    .H(8), .W(8), .K(3), .C(1), .DW(8), .STRIDE(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_i       (req_i),
    .req_j       (req_j),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .patch_valid (patch_valid),
    .patch_ready (patch_ready),
    .patch_data  (patch_data),
    .full_load   (full_load),
    .req_err     (req_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= {2'b00, mem_addr};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read scoreboard: every strobe must match the next expected address.
  always @(negedge clk) begin
    if (!rst && mem_rd_en) begin
      rd_cnt++;
      check("read_expected", 128'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) check("read_addr", mem_addr, exp_addr_q.pop_front());
    end
  end

  function automatic logic [72:0] model_patch(input int i, input int j, input logic fl);
    logic [71:0] p;
    int y, x;
    p = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        y = i - P_TB + r;
        x = j - P_TB + c;
        if (y >= 0 && y < 8 && x >= 0 && x < 8) p[(r*3+c)*8 +: 8] = 8'(y*8 + x);
      end
    end
    return {fl, p};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_reads(input int i, input int j, input int first_col);
    int y, x;
    for (int c = first_col; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        y = i - P_TB + r;
        x = j - P_TB + c;
        if (y >= 0 && y < 8 && x >= 0 && x < 8) exp_addr_q.push_back(6'(y*8 + x));
      end
    end
  endtask

  task automatic push_patch(input int i, input int j, input logic fl);
    exp_q.push_back(model_patch(i, j, fl));
  endtask

  // Returns #1 after the accept edge with req_valid already dropped.
  task automatic send_req(input int i, input int j);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_i = 3'(i);
    req_j = 3'(j);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_wait", 128'(n < 40), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_patch(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (patch_valid) break;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic take_patch(input string tag);
    logic [72:0] e;
    e = '0;
    check({tag, "_exp_avail"}, 128'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "_data"}, patch_data, e[71:0]);
    check({tag, "_full_load"}, full_load, e[72]);
    check({tag, "_reads_done"}, exp_addr_q.size(), 0);
    @(negedge clk);
    patch_ready = 1'b1;
    @(posedge clk);
    #1;
    patch_ready = 1'b0;
    check({tag, "_valid_drop"}, patch_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_patch_valid"}, patch_valid, 0);
    check({tag, "_patch_data"}, patch_data, 0);
    check({tag, "_full_load"}, full_load, 0);
    check({tag, "_req_err"}, req_err, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rd0;
    logic [71:0] held;
    rst = 1'b1;
    req_valid = 1'b0;
    req_i = '0;
    req_j = '0;
    patch_ready = 1'b0;
    mem_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

`ifdef PATCH_PAD_EN
    // Centre (0,0): four in-image taps, zero padding elsewhere.
    push_reads(0, 0, 0);
    push_patch(0, 0, 1'b1);
    send_req(0, 0);
    wait_patch("pad_full00", 10);
    take_patch("pad_full00");

    // Shift to (0,1): one new column, top tap is padding.
    push_reads(0, 1, 2);
    push_patch(0, 1, 1'b0);
    send_req(0, 1);
    wait_patch("pad_shift01", 4);
    take_patch("pad_shift01");

    // Bottom-right corner.
    push_reads(7, 7, 0);
    push_patch(7, 7, 1'b1);
    send_req(7, 7);
    wait_patch("pad_full77", 10);
    take_patch("pad_full77");

    rd0 = rd_cnt;
    push_patch(7, 7, 1'b1);
    send_req(7, 7);
    wait_patch("pad_hit77", 1);
    check("pad_hit77_no_reads", rd_cnt, rd0);
    take_patch("pad_hit77");
`else
    // Full load at (0,0).
    push_reads(0, 0, 0);
    push_patch(0, 0, 1'b1);
    send_req(0, 0);
    wait_patch("full00", 10);
    take_patch("full00");

    // Shift to (0,1).
    push_reads(0, 1, 2);
    push_patch(0, 1, 1'b0);
    send_req(0, 1);
    wait_patch("shift01", 4);
    take_patch("shift01");

    // Repeat (0,1): hit, no reads, full_load keeps 0.
    rd0 = rd_cnt;
    push_patch(0, 1, 1'b0);
    send_req(0, 1);
    wait_patch("hit01", 1);
    check("hit01_no_reads", rd_cnt, rd0);
    take_patch("hit01");

    // New row: full load.
    push_reads(1, 0, 0);
    push_patch(1, 0, 1'b1);
    send_req(1, 0);
    wait_patch("full10", 10);
    take_patch("full10");

    // Out-of-range requests are rejected with a one-cycle pulse.
    rd0 = rd_cnt;
    send_req(0, 6);
    check("err06_pulse", req_err, 1);
    check("err06_ready", req_ready, 1);
    @(posedge clk);
    #1;
    check("err06_pulse_end", req_err, 0);
    repeat (3) @(posedge clk);
    #1;
    check("err06_no_patch", patch_valid, 0);
    check("err06_no_reads", rd_cnt, rd0);
    send_req(0, 7);
    check("err07_pulse", req_err, 1);

    // The rejection dropped the held window: (1,0) is a full load again.
    push_reads(1, 0, 0);
    push_patch(1, 0, 1'b1);
    send_req(1, 0);
    wait_patch("refull10", 10);
    take_patch("refull10");

    // Shift to (1,1), then hold the patch under backpressure with a
    // competing request pending.
    push_reads(1, 1, 2);
    push_patch(1, 1, 1'b0);
    send_req(1, 1);
    wait_patch("shift11", 4);
    held = patch_data;
    @(negedge clk);
    req_valid = 1'b1;
    req_i = 3'd1;
    req_j = 3'd2;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold_valid", patch_valid, 1);
      check("hold_data", patch_data, held);
      check("hold_req_ready", req_ready, 0);
    end
    take_patch("shift11");
    check("no_same_cycle_accept_ready", req_ready, 1);
    check("no_same_cycle_accept_state", dbg_state, 0);
    push_reads(1, 2, 2);
    push_patch(1, 2, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("late_accept_state", dbg_state, 1);
    wait_patch("shift12", 4);
    take_patch("shift12");

    // Reset in the middle of a full fetch.
    push_reads(5, 5, 0);
    send_req(5, 5);
    repeat (3) @(posedge clk);
    #1;
    check("midfetch_rd_en", mem_rd_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midfetch_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_addr_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_no_patch", patch_valid, 0);

    // The aborted window must not be reused.
    push_reads(5, 5, 0);
    push_patch(5, 5, 1'b1);
    send_req(5, 5);
    wait_patch("after_reset55", 10);
    take_patch("after_reset55");
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_reads_drained", exp_addr_q.size(), 0);
    check("final_patches_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
